// File: rtl/cmp_pkg.sv
// Shared types and elaboration helpers for the slice-serial magnitude comparator.
package cmp_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

  // Slice index width; a single-slice design still needs a 1-bit counter.
  function automatic int idx_width(input int ndig);
    return (clog2(ndig) < 1) ? 1 : clog2(ndig);
  endfunction

  // Number of slices walked per compare.
  function automatic int calc_ndig(input int width, input int digit);
    return width / digit;
  endfunction

endpackage

// File: rtl/digit_cmp.sv
// Combinational compare of one slice; optional MSB flip turns the top slice
// of a two's-complement operand into an order-preserving unsigned value.
module digit_cmp #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             flip_msb,
  output logic             a_lt,
  output logic             a_gt
);

  logic [DIGIT-1:0] msb_mask;
  logic [DIGIT-1:0] a_mod;
  logic [DIGIT-1:0] b_mod;

  // Bias both slices by the sign bit when requested, then compare unsigned.
  always_comb begin
    msb_mask           = '0;
    msb_mask[DIGIT-1]  = 1'b1;
    a_mod              = flip_msb ? (a ^ msb_mask) : a;
    b_mod              = flip_msb ? (b ^ msb_mask) : b;
    a_lt               = (a_mod < b_mod);
    a_gt               = (a_mod > b_mod);
  end

endmodule

// File: rtl/seq_mag_comparator.sv
// Slice-serial magnitude comparator: walks operands MSB slice first, stops at
// the first differing slice, falls back to the cascade inputs when all match.
module seq_mag_comparator
  import cmp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             l,
  input  logic             e,
  input  logic             g,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int IDX_W = idx_width(NDIG);
  localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NDIG - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic             signed_reg, signed_next;
  logic             l_reg, l_next;
  logic             e_reg, e_next;
  logic             g_reg, g_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             done_reg, done_next;
  logic             lt_reg, lt_next;
  logic             eq_reg, eq_next;
  logic             gt_reg, gt_next;

  logic [DIGIT-1:0] a_slices [NDIG];
  logic [DIGIT-1:0] b_slices [NDIG];
  logic [DIGIT-1:0] a_slice;
  logic [DIGIT-1:0] b_slice;
  logic             flip_msb;
  logic             slice_lt;
  logic             slice_gt;

  // Split captured operands into slices for the index mux.
  for (genvar gi = 0; gi < NDIG; gi++) begin : g_slice
    assign a_slices[gi] = a_reg[gi*DIGIT +: DIGIT];
    assign b_slices[gi] = b_reg[gi*DIGIT +: DIGIT];
  end

  // Select the slice under examination; only the top slice carries the sign.
  always_comb begin
    a_slice  = a_slices[idx_reg];
    b_slice  = b_slices[idx_reg];
    flip_msb = signed_reg && (idx_reg == IDX_TOP);
  end

  digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a        (a_slice),
    .b        (b_slice),
    .flip_msb (flip_msb),
    .a_lt     (slice_lt),
    .a_gt     (slice_gt)
  );

  // Next-state, capture and result logic; everything holds unless updated.
  always_comb begin
    state_next  = state_reg;
    a_next      = a_reg;
    b_next      = b_reg;
    signed_next = signed_reg;
    l_next      = l_reg;
    e_next      = e_reg;
    g_next      = g_reg;
    idx_next    = idx_reg;
    done_next   = 1'b0;
    lt_next     = lt_reg;
    eq_next     = eq_reg;
    gt_next     = gt_reg;

    case (state_reg)
      IDLE, DONE: begin
        // Results stay untouched here so they remain readable until the
        // next compare actually finishes.
        if (start) begin
          a_next      = A;
          b_next      = B;
          signed_next = is_signed;
          l_next      = l;
          e_next      = e;
          g_next      = g;
          idx_next    = IDX_TOP;
          state_next  = RUN;
        end
      end
      RUN: begin
        // start is deliberately ignored while a compare is in flight.
        if (slice_lt || slice_gt) begin
          lt_next    = slice_lt;
          eq_next    = 1'b0;
          gt_next    = slice_gt;
          done_next  = 1'b1;
          state_next = DONE;
        end else if (idx_reg != '0) begin
          idx_next = idx_reg - 1'b1;
        end else begin
          // All slices equal: pass the cascade through verbatim.
          lt_next    = l_reg;
          eq_next    = e_reg;
          gt_next    = g_reg;
          done_next  = 1'b1;
          state_next = DONE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      signed_reg <= 1'b0;
      l_reg      <= 1'b0;
      e_reg      <= 1'b0;
      g_reg      <= 1'b0;
      idx_reg    <= '0;
      done_reg   <= 1'b0;
      lt_reg     <= 1'b0;
      eq_reg     <= 1'b0;
      gt_reg     <= 1'b0;
    end else begin
      state_reg  <= state_next;
      a_reg      <= a_next;
      b_reg      <= b_next;
      signed_reg <= signed_next;
      l_reg      <= l_next;
      e_reg      <= e_next;
      g_reg      <= g_next;
      idx_reg    <= idx_next;
      done_reg   <= done_next;
      lt_reg     <= lt_next;
      eq_reg     <= eq_next;
      gt_reg     <= gt_next;
    end
  end

  assign busy = (state_reg == RUN);
  assign done = done_reg;
  assign lt   = lt_reg;
  assign eq   = eq_reg;
  assign gt   = gt_reg;

endmodule

// File: tb/tb_seq_mag_comparator.sv
module tb_seq_mag_comparator;

  logic clk = 1'b0;
  logic rst;

  logic        start32, sgn32, l32, e32, g32;
  logic [31:0] a32, b32;
  logic        busy32, done32, lt32, eq32, gt32;

  logic        start8, sgn8, l8, e8, g8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, lt8, eq8, gt8;

  int n_cmp = 0;
  int n_bad = 0;
  int cur   = 0;

  logic prev_lt [2];
  logic prev_eq [2];
  logic prev_gt [2];

  logic o_busy, o_done, o_lt, o_eq, o_gt;

  always #5 clk = ~clk;

  assign o_busy = (cur != 0) ? busy8 : busy32;
  assign o_done = (cur != 0) ? done8 : done32;
  assign o_lt   = (cur != 0) ? lt8   : lt32;
  assign o_eq   = (cur != 0) ? eq8   : eq32;
  assign o_gt   = (cur != 0) ? gt8   : gt32;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  seq_mag_comparator #(.WIDTH(32), .DIGIT(8)) dut32 (
    .clk(clk), .rst(rst), .start(start32), .is_signed(sgn32),
    .A(a32), .B(b32), .l(l32), .e(e32), .g(g32),
    .busy(busy32), .done(done32), .lt(lt32), .eq(eq32), .gt(gt32)
  );

  seq_mag_comparator #(.WIDTH(8), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .is_signed(sgn8),
    .A(a8), .B(b8), .l(l8), .e(e8), .g(g8),
    .busy(busy8), .done(done8), .lt(lt8), .eq(eq8), .gt(gt8)
  );

  task automatic model(input int w, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic l, input logic e, input logic g,
                       output logic xl, output logic xe, output logic xg, output int k);
    longint sa, sb;
    logic [31:0] am, bm;
    int ndig;
    am = (w == 32) ? a : (a & ((32'd1 << w) - 1));
    bm = (w == 32) ? b : (b & ((32'd1 << w) - 1));
    if (sgn) begin
      sa = longint'($signed(am << (32 - w))) >>> (32 - w);
      sb = longint'($signed(bm << (32 - w))) >>> (32 - w);
    end else begin
      sa = longint'({32'd0, am});
      sb = longint'({32'd0, bm});
    end
    if (sa == sb) begin
      xl = l; xe = e; xg = g;
    end else begin
      xl = (sa < sb); xe = 1'b0; xg = (sa > sb);
    end
    ndig = w / 8;
    k = 0;
    for (int s = ndig - 1; s >= 0; s--) begin
      k++;
      if (((am >> (s * 8)) & 32'hFF) != ((bm >> (s * 8)) & 32'hFF)) break;
    end
  endtask

  task automatic drive(input int sel, input logic st, input logic [31:0] a, input logic [31:0] b,
                       input logic sgn, input logic l, input logic e, input logic g);
    if (sel != 0) begin
      start8 = st; a8 = a[7:0]; b8 = b[7:0]; sgn8 = sgn; l8 = l; e8 = e; g8 = g;
    end else begin
      start32 = st; a32 = a; b32 = b; sgn32 = sgn; l32 = l; e32 = e; g32 = g;
    end
  endtask

  task automatic run_op(input int sel, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input logic l, input logic e, input logic g,
                        input bit tail, input bit poke, input string name);
    logic xl, xe, xg;
    int   k, got_k, w, limit;
    bit   poking;
    w = (sel != 0) ? 8 : 32;
    model(w, a, b, sgn, l, e, g, xl, xe, xg, k);
    cur = sel;
    drive(sel, 1'b1, a, b, sgn, l, e, g);
    @(negedge clk);
    drive(sel, 1'b0, $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 1));
    check({name, "/busy_start"}, o_busy, 1'b1);
    check({name, "/done_start"}, o_done, 1'b0);
    check({name, "/hold_lt"}, o_lt, prev_lt[sel]);
    check({name, "/hold_eq"}, o_eq, prev_eq[sel]);
    check({name, "/hold_gt"}, o_gt, prev_gt[sel]);
    got_k  = 0;
    poking = 1'b0;
    limit  = w / 8 + 3;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clk);
      if (poking) begin
        drive(sel, 1'b0, $urandom, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        poking = 1'b0;
      end
      if (o_done) begin
        got_k = c;
        break;
      end
      check({name, "/busy_run"}, o_busy, 1'b1);
      check({name, "/hold_eq_run"}, o_eq, prev_eq[sel]);
      if (poke && c == 1) begin
        drive(sel, 1'b1, ~a, b ^ 32'h0100_0000, ~sgn, ~l, ~e, ~g);
        poking = 1'b1;
      end
    end
    if (poking) drive(sel, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (got_k == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s/timeout: no done within %0d cycles", name, limit);
    end
    check({name, "/latency"}, got_k, k);
    check({name, "/lt"}, o_lt, xl);
    check({name, "/eq"}, o_eq, xe);
    check({name, "/gt"}, o_gt, xg);
    check({name, "/busy_done"}, o_busy, 1'b0);
    $display("op %s: A=%08h B=%08h sgn=%0d lge=%0d%0d%0d -> lt=%0d eq=%0d gt=%0d k=%0d (exp %0d%0d%0d k=%0d)",
             name, a, b, sgn, l, e, g, o_lt, o_eq, o_gt, got_k, xl, xe, xg, k);
    prev_lt[sel] = xl;
    prev_eq[sel] = xe;
    prev_gt[sel] = xg;
    if (tail) begin
      @(negedge clk);
      check({name, "/done_pulse"}, o_done, 1'b0);
      check({name, "/busy_after"}, o_busy, 1'b0);
      check({name, "/hold_after"}, o_eq, xe);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, mask;
    int          keep;
    rst = 1'b1;
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      prev_lt[i] = 1'b0; prev_eq[i] = 1'b0; prev_gt[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("reset/busy32", busy32, 1'b0);
    check("reset/done32", done32, 1'b0);
    check("reset/res32", {lt32, eq32, gt32}, 3'b000);
    check("reset/busy8", busy8, 1'b0);
    check("reset/res8", {lt8, eq8, gt8}, 3'b000);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 32'h41414141, 32'h41414141, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "eq_e");
    run_op(0, 32'h41414141, 32'h41414141, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "eq_l");
    run_op(0, 32'h40000000, 32'h0D000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "msb_gt");
    run_op(0, 32'h1F000000, 32'h80000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "msb_lt");
    run_op(0, 32'h80000000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "uns");
    run_op(0, 32'h80000000, 32'h00000001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "sgn");
    run_op(0, 32'h12345678, 32'h12345679, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, "lsb_poke");

    cur = 0;
    drive(0, 1'b1, 32'h41414141, 32'h41414141, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst/busy", busy32, 1'b0);
    check("midrst/done", done32, 1'b0);
    check("midrst/res", {lt32, eq32, gt32}, 3'b000);
    $display("op midrst: busy=%0d done=%0d res=%0d%0d%0d", busy32, done32, lt32, eq32, gt32);
    for (int i = 0; i < 2; i++) begin
      prev_lt[i] = 1'b0; prev_eq[i] = 1'b0; prev_gt[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    check("midrst/no_done", done32, 1'b0);
    run_op(0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "after_rst");

    run_op(1, 32'h41, 32'h41, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "n1_eq");
    run_op(1, 32'h40, 32'h0D, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "n1_gt");
    run_op(1, 32'h80, 32'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "n1_sgn");

    for (int i = 0; i < 40; i++) begin
      ra   = $urandom;
      keep = $urandom_range(0, 4);
      mask = (keep == 4) ? 32'hFFFFFFFF : ~(32'hFFFFFFFF >> (keep * 8));
      rb   = (ra & mask) | ($urandom & ~mask);
      if ($urandom_range(0, 3) == 0) rb = ra;
      run_op(0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, "rnd32");
      run_op(1, $urandom, $urandom_range(0, 3) == 0 ? ra : $urandom, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'b0, "rnd8");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_mag_comparator.md
Name: seq_mag_comparator

Overview:
- Multi-cycle, parametrised successor to the team's 8-bit cascadable magnitude comparator.
- Compares two WIDTH-bit operands one DIGIT-bit slice per clock, MSB slice first, and stops early at the first differing slice.
- Supports unsigned and two's-complement signed modes and keeps the lt/eq/gt cascade inputs for chaining.
- Uses a start/busy/done handshake so it can sit behind a register file or bus master in the lab datapath.

Parameters:
WIDTH, 32, operand width in bits; must be a multiple of DIGIT and at least DIGIT.
DIGIT, 8, slice width in bits compared per clock; NDIG = WIDTH/DIGIT slices.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  synchronous, active-high reset.
start  input  1  request pulse; sampled only when not busy.
is_signed  input  1  1 = two's-complement compare, 0 = unsigned; captured with start.
A  input  WIDTH  operand A; captured with start.
B  input  WIDTH  operand B; captured with start.
l  input  1  cascade less-than from a less-significant stage; captured with start.
e  input  1  cascade equal; captured with start.
g  input  1  cascade greater-than; captured with start.
busy  output  1  high while a compare is in progress.
done  output  1  one-cycle pulse when the result becomes valid.
lt  output  1  result A<B, registered.
eq  output  1  result A==B, registered.
gt  output  1  result A>B, registered.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). Reset forces IDLE, busy=0, done=0, lt=eq=gt=0 and idx=0. This applies from any state, including mid-compare; the in-flight operation is discarded.
- States:
  - IDLE: start=1 at an edge captures A, B, is_signed, l, e, g, sets idx=NDIG-1 and moves to RUN. busy=1 from the next cycle.
  - RUN: each edge compares slice idx of A against slice idx of B.
    - If the slices differ: register lt/gt from the slice compare, set eq=0, pulse done and go to DONE.
    - If the slices are equal and idx>0: decrement idx and stay in RUN.
    - If the slices are equal and idx==0: register lt=l, eq=e, gt=g (cascade inputs passed verbatim, no priority fix-up), pulse done and go to DONE.
  - DONE: busy=0, done=0, and the results hold. start=1 behaves exactly as in IDLE. Otherwise the block stays in DONE.
- Latency: done is high in the cycle after edge t0+k, where t0 is the edge that sampled start and k is the number of slices examined (1..NDIG).
  - Best case is 1 cycle.
  - Equal operands take NDIG cycles.
- Signed mode: invert the top bit of slice NDIG-1 of both operands before comparing. All other slices are compared unsigned. Unsigned mode compares every slice as unsigned.
- start while busy is ignored: no capture, no error, and the in-flight result is unaffected.
- lt/eq/gt change only on the edge that asserts done (or on reset). Between operations they hold the last result, including through a new start until that compare's done.
- A/B changing after the capture edge have no effect.
- NDIG=1 is legal: every compare completes in 1 cycle.

Decomposition:
- Package cmp_pkg holds:
  - the state encoding localparams IDLE/RUN/DONE (2-bit);
  - a clog2 function for the idx width;
  - the NDIG derivation.
- One natural sub-module, digit_cmp: combinational, DIGIT-bit inputs a and b plus a flip_msb flag, outputs a_lt and a_gt.
- seq_mag_comparator holds the FSM, capture registers, idx counter and slice mux.

Test Plan (WIDTH=32, DIGIT=8 unless noted):
1. Equal operands: A=B=32'h41414141, l=0,e=1,g=0, unsigned -> done after exactly 4 cycles, eq=1, lt=gt=0. Repeat with l=1,e=0,g=0 -> lt=1, eq=0, gt=0 after 4 cycles.
2. Early exit on the MSB slice: A=32'h40000000, B=32'h0D000000, unsigned -> done after 1 cycle, gt=1. Then A=32'h1F000000, B=32'h80000000 -> lt=1 after 1 cycle.
3. Signed vs unsigned on the same operands: A=32'h80000000, B=32'h00000001. Unsigned -> gt=1, 1 cycle. Signed -> lt=1, 1 cycle.
4. Difference only in the LSB slice: A=32'h12345678, B=32'h12345679 -> done after 4 cycles, lt=1. A second start raised during busy is ignored; busy and done are seen exactly once.
5. Reset mid-operation: start an equal compare, assert rst at cycle 2 -> next cycle busy=0, done=0, lt=eq=gt=0, state IDLE. A fresh start then completes normally.
6. Back-to-back and NDIG=1: with WIDTH=8, DIGIT=8, issue start every other cycle with A=8'h41, B=8'h41 (e=1), then A=8'h40, B=8'h0D -> each done comes 1 cycle after its start, results eq=1 then gt=1, held between operations.
